// File: rtl/alu_exec_unit_pkg.sv
// Shared constants, opcode encoding and decode helpers for the ALU execute unit.
package alu_exec_unit_pkg;

  localparam int unsigned DataW   = 32;
  localparam int unsigned FlagW   = 4;
  localparam int unsigned OptypeW = 3;

  // Flag bit positions within {N,Z,C,V}
  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  // Upper two optype bits classify the instruction
  localparam logic [1:0] OptData = 2'b00;
  localparam logic [1:0] OptLdSt = 2'b01;

  typedef enum logic [3:0] {
    OpAnd = 4'h0, OpEor = 4'h1, OpSub = 4'h2, OpRsb = 4'h3,
    OpAdd = 4'h4, OpAdc = 4'h5, OpSbc = 4'h6, OpRsc = 4'h7,
    OpTst = 4'h8, OpTeq = 4'h9, OpCmp = 4'hA, OpCmn = 4'hB,
    OpOrr = 4'hC, OpMov = 4'hD, OpBic = 4'hE, OpMvn = 4'hF
  } alu_op_e;

  function automatic logic is_test_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  function automatic logic is_logical_op(input logic [3:0] op);
    return op inside {OpAnd, OpEor, OpTst, OpTeq, OpOrr, OpMov, OpBic, OpMvn};
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU producing the result and next {N,Z,C,V}.
module alu_core
  import alu_exec_unit_pkg::*;
(
  input  logic [3:0]       i_opcode,
  input  logic [DataW-1:0] i_rn,
  input  logic [DataW-1:0] i_shifter,
  input  logic             i_shifter_carry,
  input  logic             i_carry,
  input  logic             i_overflow,
  output logic [DataW-1:0] o_result,
  output logic [FlagW-1:0] o_flags_next
);

  logic [DataW-1:0] w_a;
  logic [DataW-1:0] w_b;
  logic             w_cin;
  logic [DataW:0]   w_sum;
  logic             w_logical;

  // Subtractions are a + ~b + cin so the carry-out is already NOT borrow
  always_comb begin
    w_a   = i_rn;
    w_b   = i_shifter;
    w_cin = 1'b0;
    unique case (i_opcode)
      OpSub, OpCmp: begin w_b = ~i_shifter; w_cin = 1'b1; end
      OpRsb:        begin w_a = i_shifter; w_b = ~i_rn; w_cin = 1'b1; end
      OpAdc:        w_cin = i_carry;
      OpSbc:        begin w_b = ~i_shifter; w_cin = i_carry; end
      OpRsc:        begin w_a = i_shifter; w_b = ~i_rn; w_cin = i_carry; end
      default:      ;
    endcase
  end

  assign w_sum     = {1'b0, w_a} + {1'b0, w_b} + {{DataW{1'b0}}, w_cin};
  assign w_logical = is_logical_op(i_opcode);

  always_comb begin
    o_result = w_sum[DataW-1:0];
    unique case (i_opcode)
      OpAnd, OpTst: o_result = i_rn & i_shifter;
      OpEor, OpTeq: o_result = i_rn ^ i_shifter;
      OpOrr:        o_result = i_rn | i_shifter;
      OpMov:        o_result = i_shifter;
      OpBic:        o_result = i_rn & ~i_shifter;
      OpMvn:        o_result = ~i_shifter;
      default:      ;
    endcase
  end

  always_comb begin
    o_flags_next        = '0;
    o_flags_next[FlagN] = o_result[DataW-1];
    o_flags_next[FlagZ] = (o_result == '0);
    if (w_logical) begin
      o_flags_next[FlagC] = i_shifter_carry;
      o_flags_next[FlagV] = i_overflow;
    end else begin
      o_flags_next[FlagC] = w_sum[DataW];
      o_flags_next[FlagV] = (w_a[DataW-1] == w_b[DataW-1]) &&
                            (w_sum[DataW-1] != w_a[DataW-1]);
    end
  end

endmodule

// File: rtl/alu_decoder.sv
// Maps optype/control fields to an ALU operation and the flag write mask.
module alu_decoder
  import alu_exec_unit_pkg::*;
(
  input  logic [OptypeW-1:0] i_optype,
  input  logic [4:0]         i_control,
  output logic [3:0]         o_alu_opcode,
  output logic [FlagW-1:0]   o_set_mask
);

  logic [3:0] w_op;
  logic       w_s;

  assign w_s = i_control[0];

  always_comb begin
    w_op       = OpMov;
    o_set_mask = 4'b0000;
    if (i_optype[2:1] == OptData) begin
      w_op = i_control[4:1];
      if (is_test_op(w_op)) begin
        o_set_mask = w_op[1] ? 4'b1111 : 4'b1110;
      end else if (w_s) begin
        o_set_mask = is_logical_op(w_op) ? 4'b1110 : 4'b1111;
      end
    end else if (i_optype[2:1] == OptLdSt) begin
      // control[3] is the U (up/down) bit
      w_op = i_control[3] ? OpAdd : OpSub;
    end
  end

  assign o_alu_opcode = w_op;

endmodule

// File: rtl/alu_hazard.sv
// Detects when the older data-processing result must be forwarded.
module alu_hazard
  import alu_exec_unit_pkg::*;
(
  input  logic [OptypeW-1:0] i_prev_optype,
  input  logic [3:0]         i_prev_opcode,
  input  logic [3:0]         i_prev_rd,
  input  logic [3:0]         i_curr_reg,
  output logic               o_bypass
);

  // Test ops write no register, so they never forward
  assign o_bypass = (i_prev_optype[2:1] == OptData) && !is_test_op(i_prev_opcode) &&
                    (i_prev_rd == i_curr_reg);

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: decoder, datapath, forwarding check and the CPSR flag register.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_nreset,
  input  logic [OptypeW-1:0] i_optype,
  input  logic [4:0]         i_control,
  input  logic [DataW-1:0]   i_rn,
  input  logic [DataW-1:0]   i_shifter,
  input  logic               i_shifter_carry,
  input  logic               i_ex_valid,
  input  logic [OptypeW-1:0] i_prev_optype,
  input  logic [3:0]         i_prev_opcode,
  input  logic [3:0]         i_prev_rd,
  input  logic [3:0]         i_curr_reg,
  output logic [3:0]         o_alu_opcode,
  output logic [FlagW-1:0]   o_set_mask,
  output logic [DataW-1:0]   o_result,
  output logic [FlagW-1:0]   o_flags_next,
  output logic [FlagW-1:0]   o_cpsr_flags,
  output logic               o_bypass
);

  logic [FlagW-1:0] r_flags;
  logic [FlagW-1:0] w_we;

  alu_decoder u_decoder (
    .i_optype     (i_optype),
    .i_control    (i_control),
    .o_alu_opcode (o_alu_opcode),
    .o_set_mask   (o_set_mask)
  );

  alu_core u_core (
    .i_opcode        (o_alu_opcode),
    .i_rn            (i_rn),
    .i_shifter       (i_shifter),
    .i_shifter_carry (i_shifter_carry),
    .i_carry         (r_flags[FlagC]),
    .i_overflow      (r_flags[FlagV]),
    .o_result        (o_result),
    .o_flags_next    (o_flags_next)
  );

  alu_hazard u_hazard (
    .i_prev_optype (i_prev_optype),
    .i_prev_opcode (i_prev_opcode),
    .i_prev_rd     (i_prev_rd),
    .i_curr_reg    (i_curr_reg),
    .o_bypass      (o_bypass)
  );

  assign w_we = o_set_mask & {FlagW{i_ex_valid}};

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_flags <= '0;
    end else begin
      r_flags <= (o_flags_next & w_we) | (r_flags & ~w_we);
    end
  end

  assign o_cpsr_flags = r_flags;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit using hand-computed directed vectors.
module tb_alu_exec_unit;

  logic        clk;
  logic        nreset;
  logic [2:0]  optype;
  logic [4:0]  control;
  logic [31:0] rn;
  logic [31:0] shifter;
  logic        shifter_carry;
  logic        ex_valid;
  logic [2:0]  prev_optype;
  logic [3:0]  prev_opcode;
  logic [3:0]  prev_rd;
  logic [3:0]  curr_reg;
  logic [3:0]  alu_opcode;
  logic [3:0]  set_mask;
  logic [31:0] result;
  logic [3:0]  flags_next;
  logic [3:0]  cpsr_flags;
  logic        bypass;

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [3:0]  mask;
    logic [31:0] res;
    logic [3:0]  flags;
    logic [3:0]  cpsr;
    logic        byp;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_exec_unit dut (
    .i_clk           (clk),
    .i_nreset        (nreset),
    .i_optype        (optype),
    .i_control       (control),
    .i_rn            (rn),
    .i_shifter       (shifter),
    .i_shifter_carry (shifter_carry),
    .i_ex_valid      (ex_valid),
    .i_prev_optype   (prev_optype),
    .i_prev_opcode   (prev_opcode),
    .i_prev_rd       (prev_rd),
    .i_curr_reg      (curr_reg),
    .o_alu_opcode    (alu_opcode),
    .o_set_mask      (set_mask),
    .o_result        (result),
    .o_flags_next    (flags_next),
    .o_cpsr_flags    (cpsr_flags),
    .o_bypass        (bypass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: outputs for the vector driven after a rising edge are checked at the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("alu_opcode", e.id, {28'd0, alu_opcode}, {28'd0, e.op});
      chk("set_mask",   e.id, {28'd0, set_mask},   {28'd0, e.mask});
      chk("result",     e.id, result,              e.res);
      chk("flags_next", e.id, {28'd0, flags_next}, {28'd0, e.flags});
      chk("cpsr_flags", e.id, {28'd0, cpsr_flags}, {28'd0, e.cpsr});
      chk("bypass",     e.id, {31'd0, bypass},     {31'd0, e.byp});
    end
  end

  int vec_id = 0;

  task automatic issue(input logic [2:0] ot, input logic [4:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic sc, input logic ev,
                       input logic [2:0] pot, input logic [3:0] pop, input logic [3:0] prd,
                       input logic [3:0] cr, input logic [3:0] e_op, input logic [3:0] e_mask,
                       input logic [31:0] e_res, input logic [3:0] e_fl,
                       input logic [3:0] e_cpsr, input logic e_byp);
    exp_t e;
    @(posedge clk);
    #1;
    optype = ot; control = ctl; rn = a; shifter = b; shifter_carry = sc; ex_valid = ev;
    prev_optype = pot; prev_opcode = pop; prev_rd = prd; curr_reg = cr;
    vec_id++;
    e.id = vec_id; e.op = e_op; e.mask = e_mask; e.res = e_res;
    e.flags = e_fl; e.cpsr = e_cpsr; e.byp = e_byp;
    q.push_back(e);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    n_tests++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left after %0d cycles, expected 0", q.size(), budget);
      q.delete();
    end
  endtask

  localparam logic [2:0] NA = 3'b100;

  initial begin
    nreset = 1'b0; optype = 3'b000; control = 5'd0; rn = '0; shifter = '0;
    shifter_carry = 1'b0; ex_valid = 1'b0; prev_optype = NA; prev_opcode = 4'h0;
    prev_rd = 4'h0; curr_reg = 4'h0;
    #12;
    chk("reset_cpsr", 0, {28'd0, cpsr_flags}, 32'd0);
    nreset = 1'b1;

    //    optype  ctl       rn            sh            sc ev  pot     pop   rd    cr
    //    op     mask     result        flags    cpsr   byp
    issue(3'b000, 5'b01001, 32'hFFFFFFFF, 32'h1,        0, 1, 3'b000, 4'h4, 4'h3, 4'h3,
          4'h4, 4'b1111, 32'h0,        4'b0110, 4'b0000, 1);  // ADD wrap
    issue(3'b000, 5'b10100, 32'h5,        32'h7,        0, 0, 3'b000, 4'hA, 4'h3, 4'h3,
          4'hA, 4'b1111, 32'hFFFFFFFE, 4'b1000, 4'b0110, 0);  // CMP, ex_valid=0
    issue(3'b000, 5'b01001, 32'h7FFFFFFF, 32'h1,        0, 1, 3'b010, 4'h4, 4'h3, 4'h3,
          4'h4, 4'b1111, 32'h80000000, 4'b1001, 4'b0110, 0);  // ADD overflow
    issue(3'b000, 5'b10100, 32'h5,        32'h5,        0, 1, 3'b000, 4'h4, 4'h3, 4'h4,
          4'hA, 4'b1111, 32'h0,        4'b0110, 4'b1001, 0);  // CMP equal sets C
    issue(3'b000, 5'b01010, 32'h2,        32'h3,        0, 1, 3'b001, 4'hD, 4'hF, 4'hF,
          4'h5, 4'b0000, 32'h6,        4'b0000, 4'b0110, 1);  // ADC C=1, r15 bypass
    issue(3'b010, 5'b10000, 32'h100,      32'h4,        0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'h2, 4'b0000, 32'hFC,       4'b0010, 4'b0110, 0);  // LDST U=0
    issue(3'b011, 5'b11000, 32'h100,      32'h4,        0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'h4, 4'b0000, 32'h104,      4'b0000, 4'b0110, 0);  // LDST U=1
    issue(3'b101, 5'b00000, 32'h0,        32'hDEADBEEF, 1, 1, NA,     4'h0, 4'h0, 4'h0,
          4'hD, 4'b0000, 32'hDEADBEEF, 4'b1010, 4'b0110, 0);  // non-ALU -> MOV
    issue(3'b000, 5'b00001, 32'hF0F0F0F0, 32'hFF00FF00, 0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'h0, 4'b1110, 32'hF000F000, 4'b1000, 4'b0110, 0);  // ANDS
    issue(3'b000, 5'b00101, 32'h80000000, 32'h1,        0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'h2, 4'b1111, 32'h7FFFFFFF, 4'b0011, 4'b1000, 0);  // SUBS overflow
    issue(3'b000, 5'b11111, 32'h12345678, 32'h0,        1, 1, NA,     4'h0, 4'h0, 4'h0,
          4'hF, 4'b1110, 32'hFFFFFFFF, 4'b1011, 4'b0011, 0);  // MVNS keeps V
    issue(3'b000, 5'b00111, 32'h1,        32'h0,        0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'h3, 4'b1111, 32'hFFFFFFFF, 4'b1000, 4'b1011, 0);  // RSBS borrow
    issue(3'b000, 5'b01101, 32'd10,       32'd3,        0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'h6, 4'b1111, 32'd6,        4'b0010, 4'b1000, 0);  // SBCS C=0
    issue(3'b000, 5'b01111, 32'd4,        32'd9,        0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'h7, 4'b1111, 32'd5,        4'b0010, 4'b0010, 0);  // RSCS C=1
    issue(3'b000, 5'b10010, 32'h5,        32'h5,        0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'h9, 4'b1110, 32'h0,        4'b0100, 4'b0010, 0);  // TEQ with S=0
    issue(3'b000, 5'b11000, 32'h1,        32'h2,        0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'hC, 4'b0000, 32'h3,        4'b0000, 4'b0100, 0);  // ORR no S
    issue(3'b000, 5'b11101, 32'hFF,       32'h0F,       0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'hE, 4'b1110, 32'hF0,       4'b0000, 4'b0100, 0);  // BICS
    issue(3'b000, 5'b10110, 32'hFFFFFFFF, 32'h1,        0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'hB, 4'b1111, 32'h0,        4'b0110, 4'b0000, 0);  // CMN
    issue(3'b000, 5'b00010, 32'hFF,       32'h0F,       0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'h1, 4'b0000, 32'hF0,       4'b0000, 4'b0110, 0);  // EOR no S
    drain();

    // Asynchronous reset between clock edges; combinational result must not move
    @(posedge clk);
    #2;
    chk("pre_reset_cpsr", 100, {28'd0, cpsr_flags}, 32'h6);
    nreset = 1'b0;
    #1;
    chk("async_reset_cpsr", 101, {28'd0, cpsr_flags}, 32'h0);
    chk("reset_result", 102, result, 32'hF0);
    #3;
    nreset = 1'b1;

    issue(3'b000, 5'b01001, 32'hFFFFFFFF, 32'h1,        0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'h4, 4'b1111, 32'h0,        4'b0110, 4'b0000, 0);  // ADDS after reset
    issue(3'b000, 5'b11010, 32'h0,        32'h5,        0, 1, NA,     4'h0, 4'h0, 4'h0,
          4'hD, 4'b0000, 32'h5,        4'b0000, 4'b0110, 0);  // MOV sees updated flags
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion before 50000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 clk  input  1  rising-edge clock for the flag register.
REQ-002 nreset  input  1  asynchronous, active-low reset.
REQ-003 optype  input  3  instruction bits [27:25]; 00x = data-processing, 01x = load/store, others = non-ALU.
REQ-004 control  input  5  instruction bits [24:20]; data: {opcode[3:0], S}; load/store: {P, U, B, W, L}.
REQ-005 rn  input  32  first operand, already forwarded.
REQ-006 shifter  input  32  second operand from the shifter.
REQ-007 shifter_carry  input  1  shifter carry-out.
REQ-008 ex_valid  input  1  condition passed and not squashed; gates flag writes.
REQ-009 prev_optype  input  3  optype of the instruction one stage ahead (EX/ME).
REQ-010 prev_opcode  input  4  opcode field [24:21] of that instruction.
REQ-011 prev_rd, curr_reg  input  4 each  destination of the older instruction; source register being read now.
REQ-012 alu_opcode  output  4  decoded operation.
REQ-013 set_mask  output  4  flag write enables {N,Z,C,V}.
REQ-014 result  output  32  combinational ALU result.
REQ-015 flags_next  output  4  combinational {N,Z,C,V} from this operation.
REQ-016 cpsr_flags  output  4  registered {N,Z,C,V}.
REQ-017 bypass  output  1  forward the older ALU result to curr_reg.

Function
REQ-018 Opcode encoding follows ARM: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, A CMP, B CMN, C ORR, D MOV, E BIC, F MVN.
REQ-019 Data optype: alu_opcode = control[4:1].
REQ-020 Load/store optype: alu_opcode = ADD when U = 1, SUB when U = 0.
REQ-021 Any other optype: alu_opcode = MOV.
REQ-022 set_mask, data optype: TST, TEQ, CMP, CMN give 1110/1110/1111/1111 regardless of S.
REQ-023 set_mask, other data ops with S = 1: logical ops (AND, EOR, ORR, MOV, BIC, MVN) give 1110; arithmetic ops give 1111.
REQ-024 set_mask is 0000 when S = 0 (except REQ-022) and for every non-data optype.
REQ-025 Result per op: AND rn&sh; EOR rn^sh; SUB rn-sh; RSB sh-rn; ADD rn+sh; ADC rn+sh+C; SBC rn-sh-!C; RSC sh-rn-!C; TST/TEQ/CMP/CMN same as AND/EOR/SUB/ADD; ORR rn|sh; MOV sh; BIC rn&~sh; MVN ~sh. C is cpsr_flags C.
REQ-026 All arithmetic is 32-bit modulo 2^32 (wrap).
REQ-027 N = result[31]; Z = (result == 0).
REQ-028 C for additions = carry-out of bit 31; for subtractions = NOT borrow; for logical ops = shifter_carry.
REQ-029 V = signed overflow for arithmetic ops; for logical ops V = current cpsr V.
REQ-030 On each rising clk, for each bit i, cpsr_flags[i] <= flags_next[i] when set_mask[i] & ex_valid; otherwise it holds.
REQ-031 bypass = 1 iff prev_optype[2:1] = 00, prev_opcode is not TST/TEQ/CMP/CMN, and prev_rd == curr_reg (r15 included).
REQ-032 All outputs except cpsr_flags are purely combinational (zero latency).

Reset
REQ-033 nreset low asynchronously clears cpsr_flags to 0000; combinational outputs are unaffected.
REQ-034 Flag updates resume on the first rising clk after nreset deasserts.

Structure
REQ-035 Opcode constants, optype codes, flag bit indices and widths (32, 4, 3) belong in the shared defines package.
REQ-036 The top instantiates three sub-modules: alu_decoder (REQ-019..024), alu_core (REQ-025..029), alu_hazard (REQ-031); the flag register lives in the top.

Verification
REQ-037 ADD, S = 1: rn = FFFFFFFF, sh = 1, ex_valid = 1 -> result 0, flags_next 0110; after clk cpsr_flags = 0110.
REQ-038 CMP: rn = 5, sh = 7 -> result FFFFFFFE, flags_next 1000; with ex_valid = 0, cpsr_flags unchanged after clk.
REQ-039 ADD: rn = 7FFFFFFF, sh = 1, S = 1 -> result 80000000, NZCV = 1001. Then ADC with C = 1: rn = 2, sh = 3 -> result 6.
REQ-040 Load/store with U = 0: rn = 100, sh = 4 -> alu_opcode SUB, result FC, set_mask 0000.
REQ-041 Hazard: prev ADD with prev_rd = 3, curr_reg = 3 -> bypass 1. Prev CMP -> 0. Prev load/store optype 010 -> 0. curr_reg = 4 -> 0.
REQ-042 Reset: assert nreset mid-run with cpsr_flags = 1111 -> 0000 immediately, without a clock edge.
